// File: rtl/add_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : add_stage_pkg
// Description : Shared width constant and FSM state encoding for add_stage.
// Revision    : 1.0
// ============================================================================
package add_stage_pkg;

  localparam int c_width_default = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage : add_stage_pkg
`default_nettype wire

// File: rtl/rca32.sv
`default_nettype none
// ============================================================================
// Module      : rca32
// Description : 32-bit ripple-carry adder, purely combinational.
// Revision    : 1.0
// ============================================================================
module rca32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [32:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
  end

  assign cout = w_carry[32];

endmodule : rca32
`default_nettype wire

// File: rtl/add_stage.sv
`default_nettype none
// ============================================================================
// Module      : add_stage
// Description : Handshaked registered adder stage (IDLE/ADD/HOLD) around rca32.
//               Optional ADD_STAGE_ACC_EN adds in_acc to reuse the last sum as a.
// Revision    : 1.0
// ============================================================================
module add_stage
  import add_stage_pkg::*;
#(
  parameter int WIDTH = c_width_default
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef ADD_STAGE_ACC_EN
  input  logic             in_acc,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  state_t           r_state;
  state_t           w_next;
  logic             w_in_ready;
  logic             w_load;
  logic             w_out_valid;
  logic             w_capture;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_load      = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_next = ADD;
      end
      ADD: begin
        w_load = 1'b1;
        w_next = HOLD;
      end
      HOLD: begin
        w_out_valid = 1'b1;
        // Releasing the result frees the operand registers in the same cycle.
        if (out_ready) begin
          w_in_ready = 1'b1;
          w_next     = in_valid ? ADD : IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign in_ready  = w_in_ready & ~rst;
  assign w_capture = w_in_ready & in_valid;
  assign out_valid = w_out_valid;

`ifdef ADD_STAGE_ACC_EN
  assign w_op_a = in_acc ? r_sum : in_a;
`else
  assign w_op_a = in_a;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_cin  <= 1'b0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_capture) begin
        r_a   <= w_op_a;
        r_b   <= in_b;
        r_cin <= in_cin;
      end
      if (w_load) begin
        r_sum  <= w_sum;
        r_cout <= w_cout;
        r_ovf  <= w_ovf;
      end
    end
  end

  rca32 u_rca32 (
    .a    (r_a),
    .b    (r_b),
    .cin  (r_cin),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Signed overflow: like-signed operands producing a result of the other sign.
  assign w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);

  assign out_sum  = r_sum;
  assign out_cout = r_cout;
  assign out_ovf  = r_ovf;

endmodule : add_stage
`default_nettype wire

// File: tb/tb_add_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_stage
// Description : Directed self-checking bench for add_stage.
// Revision    : 1.0
// ============================================================================
module tb_add_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic        in_acc = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  int checks = 0;
  int errors = 0;

  add_stage #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef ADD_STAGE_ACC_EN
    .in_acc    (in_acc),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; in_a = 32'hDEAD_BEEF; in_b = 32'h1234_5678;
    tick; tick;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== 32'd0 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b ovf=%b want 0/0/0/0",
               out_valid, out_sum, out_cout, out_ovf);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    in_a = 32'd35000; in_b = 32'd35000; in_cin = 1'b0; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_accept: got in_ready=%b want 1", in_ready);
    end
    tick;
    in_valid = 1'b0; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL basic_add_cycle: got valid=%b ready=%b want 0/0", out_valid, in_ready);
    end
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 32'd70000 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got valid=%b sum=%0d cout=%b ovf=%b want 1/70000/0/0",
               out_valid, out_sum, out_cout, out_ovf);
    end
    tick;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_idle: got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_carry;
    in_a = 32'hFFFF_FFFF; in_b = 32'h0000_0001; in_cin = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 32'h0 || out_cout !== 1'b1 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL carry_wrap: got valid=%b sum=%h cout=%b ovf=%b want 1/00000000/1/0",
               out_valid, out_sum, out_cout, out_ovf);
    end
    tick;
  endtask

  task automatic test_overflow;
    in_a = 32'h7FFF_FFFF; in_b = 32'h0000_0001; in_cin = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    checks++;
    if (out_sum !== 32'h8000_0000 || out_cout !== 1'b0 || out_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_pos: got sum=%h cout=%b ovf=%b want 80000000/0/1", out_sum, out_cout, out_ovf);
    end
    // Back-to-back: next pair offered while the first result is released.
    in_a = 32'h8000_0000; in_b = 32'h8000_0000; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_accept: got in_ready=%b want 1", in_ready);
    end
    tick;
    in_valid = 1'b0;
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 32'h0 || out_cout !== 1'b1 || out_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_neg: got valid=%b sum=%h cout=%b ovf=%b want 1/00000000/1/1",
               out_valid, out_sum, out_cout, out_ovf);
    end
    tick;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    in_a = 32'h1234_5678; in_b = 32'h1111_1111; in_cin = 1'b1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    // Junk offered while held must be ignored.
    in_valid = 1'b1; in_a = 32'hAAAA_AAAA; in_b = 32'h5555_5555; in_cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 32'h2345_678A || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable[%0d]: got valid=%b sum=%h ready=%b want 1/2345678a/0",
                 i, out_valid, out_sum, in_ready);
      end
      tick;
    end
    out_ready = 1'b1; in_a = 32'd100; in_b = 32'd200; in_cin = 1'b0; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL release_accept: got in_ready=%b want 1", in_ready);
    end
    tick;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL release_add: got valid=%b want 0", out_valid);
    end
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 32'd300) begin
      errors++; $display("FAIL release_result: got valid=%b sum=%0d want 1/300", out_valid, out_sum);
    end
    tick;
  endtask

  task automatic test_reset_in_add;
    out_ready = 1'b1;
    in_a = 32'd5; in_b = 32'd6; in_cin = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    rst = 1'b1;
    tick;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== 32'd0 || out_cout !== 1'b0 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_add: got valid=%b sum=%0d cout=%b ovf=%b ready=%b want 0/0/0/0/0",
               out_valid, out_sum, out_cout, out_ovf, in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_in_add_release: got in_ready=%b want 1", in_ready);
    end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_in_add_dropped: got valid=%b want 0", out_valid);
    end
    in_a = 32'd1; in_b = 32'd2; in_cin = 1'b1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 32'd4) begin
      errors++; $display("FAIL rst_followup: got valid=%b sum=%0d want 1/4", out_valid, out_sum);
    end
    tick;
  endtask

`ifdef ADD_STAGE_ACC_EN
  task automatic test_acc;
    out_ready = 1'b1;
    in_acc = 1'b0; in_a = 32'd10; in_b = 32'd5; in_cin = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    checks++;
    if (out_sum !== 32'd15) begin
      errors++; $display("FAIL acc_first: got sum=%0d want 15", out_sum);
    end
    in_acc = 1'b1; in_a = 32'd999; in_b = 32'd7; in_valid = 1'b1;
    tick;
    in_valid = 1'b0; in_acc = 1'b0;
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 32'd22) begin
      errors++; $display("FAIL acc_second: got valid=%b sum=%0d want 1/22", out_valid, out_sum);
    end
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_overflow;
    test_backpressure;
    test_reset_in_add;
`ifdef ADD_STAGE_ACC_EN
    test_acc;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_add_stage
`default_nettype wire
